// File: rtl/pkt_buffer_ctrl.sv
// Packet buffer sequencer: streams ingress packets into consecutive RAM
// slots, replays committed packets in arrival order on the egress stream,
// and arbitrates the single RAM port between ingress writes and egress reads.
module pkt_buffer_ctrl #(
  parameter int SLOT_W = 10,
  parameter int BYTE_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              out_valid,
  output logic [7:0]        out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              ram_we,
  output logic [SLOT_W-1:0] ram_addr,
  output logic [BYTE_W-1:0] ram_byte,
  output logic [7:0]        ram_data,
  input  logic [7:0]        ram_q,
  output logic [SLOT_W:0]   pkt_count,
  output logic              drop
);

  localparam logic [SLOT_W:0] FULL_COUNT = {1'b1, {SLOT_W{1'b0}}};
  localparam logic [BYTE_W:0] LEN_ONE    = {{BYTE_W{1'b0}}, 1'b1};

  typedef enum logic {W_RUN, W_DROP} wr_state_t;
  typedef enum logic [1:0] {E_IDLE, E_ISSUE, E_CAP, E_HOLD} eg_state_t;

  wr_state_t         r_wr_state;
  eg_state_t         r_eg_state;
  logic [SLOT_W-1:0] r_wr_slot;
  logic [BYTE_W-1:0] r_wr_idx;
  logic [SLOT_W-1:0] r_rd_slot;
  logic [BYTE_W-1:0] r_rd_idx;
  logic [SLOT_W:0]   r_count;
  logic              r_prio;
  logic              r_out_valid;
  logic [7:0]        r_out_data;
  logic              r_out_last;
  logic [BYTE_W:0]   r_len [1 << SLOT_W];
  logic [BYTE_W:0]   r_len_rd;

  logic            w_full;
  logic            w_cap;
  logic            w_issue;
  logic            w_rd_issue;
  logic            w_rd_own;
  logic            w_in_ready;
  logic            w_accept;
  logic            w_wr;
  logic            w_commit;
  logic            w_retire;
  logic            w_contend;
  logic            w_last_byte;
  logic [BYTE_W:0] w_len_commit;

  assign w_full     = (r_count == FULL_COUNT);
  assign w_cap      = (r_eg_state == E_CAP);
  assign w_issue    = (r_eg_state == E_ISSUE);
  // A pending read wins when it holds priority or ingress has nothing to offer.
  assign w_rd_issue = w_issue && (r_prio || !in_valid);
  assign w_rd_own   = w_cap || w_rd_issue;
  // in_ready deliberately ignores in_valid so the handshake has no comb loop.
  assign w_in_ready = !rst && ((r_wr_state == W_DROP) ||
                      ((r_wr_state == W_RUN) && !w_full && !w_cap && !(w_issue && r_prio)));
  assign w_accept   = in_valid && w_in_ready;
  assign w_wr       = w_accept && (r_wr_state == W_RUN);
  assign w_commit   = w_wr && in_last;
  assign w_retire   = (r_eg_state == E_HOLD) && out_ready && r_out_last;
  assign w_contend  = w_issue && in_valid;
  assign w_len_commit = {1'b0, r_wr_idx} + LEN_ONE;
  // r_len_rd was fetched during E_ISSUE for the same rd_slot.
  assign w_last_byte  = ({1'b0, r_rd_idx} == (r_len_rd - LEN_ONE));

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign pkt_count = r_count;
  assign drop      = w_accept && (r_wr_state == W_DROP) && in_last;

  // RAM port mux: the read side owns the port in capture or a winning issue.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_byte = '0;
    ram_data = '0;
    if (!rst) begin
      if (w_rd_own) begin
        ram_addr = r_rd_slot;
        ram_byte = r_rd_idx;
      end else begin
        ram_addr = r_wr_slot;
        ram_byte = r_wr_idx;
        ram_we   = w_wr;
        ram_data = w_wr ? in_data : 8'h00;
      end
    end
  end

  // Length table: written at commit, read one cycle ahead of capture.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_len[r_wr_slot] <= w_len_commit;
    end
    r_len_rd <= r_len[r_rd_slot];
  end

  // Ingress sequencing: fill the current slot, commit on last, discard oversize.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_state <= W_RUN;
      r_wr_slot  <= '0;
      r_wr_idx   <= '0;
    end else if (w_accept) begin
      if (r_wr_state == W_RUN) begin
        if (in_last) begin
          r_wr_slot <= r_wr_slot + SLOT_W'(1);
          r_wr_idx  <= '0;
        end else if (&r_wr_idx) begin
          r_wr_state <= W_DROP;
          r_wr_idx   <= '0;
        end else begin
          r_wr_idx <= r_wr_idx + BYTE_W'(1);
        end
      end else if (in_last) begin
        // Oversize packet ends; slot stays uncommitted and is reused.
        r_wr_state <= W_RUN;
      end
    end
  end

  // Egress FSM: issue, capture, then hold the byte until the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_eg_state  <= E_IDLE;
      r_rd_slot   <= '0;
      r_rd_idx    <= '0;
      r_prio      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_last  <= 1'b0;
    end else begin
      // Under contention the loser gets priority next time, so prio flips.
      if (w_contend) begin
        r_prio <= ~r_prio;
      end
      case (r_eg_state)
        E_IDLE: begin
          if (r_count != '0) begin
            r_eg_state <= E_ISSUE;
          end
        end
        E_ISSUE: begin
          if (w_rd_issue) begin
            r_eg_state <= E_CAP;
          end
        end
        E_CAP: begin
          r_out_data  <= ram_q;
          r_out_last  <= w_last_byte;
          r_out_valid <= 1'b1;
          r_eg_state  <= E_HOLD;
        end
        E_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_last) begin
              r_rd_slot  <= r_rd_slot + SLOT_W'(1);
              r_rd_idx   <= '0;
              r_eg_state <= E_IDLE;
            end else begin
              r_rd_idx   <= r_rd_idx + BYTE_W'(1);
              r_eg_state <= E_ISSUE;
            end
          end
        end
        default: r_eg_state <= E_IDLE;
      endcase
    end
  end

  // Committed-packet counter; commit and retire in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_commit && !w_retire) begin
      r_count <= r_count + (SLOT_W+1)'(1);
    end else if (!w_commit && w_retire) begin
      r_count <= r_count - (SLOT_W+1)'(1);
    end
  end

endmodule

// File: doc/pkt_buffer_ctrl.md
# pkt_buffer_ctrl

Sequencer and arbiter for the single-port packet RAM of the NDN router packet buffer. Each RAM entry (slot) holds one packet of up to 2^BYTE_W bytes. Ingress packets arrive as a byte stream and are written into consecutive slots. Completed packets are read out in arrival order on an egress byte stream. The block owns the RAM's only port and time-shares it between ingress writes and egress reads.

## Interface
- SLOT_W, 10, slot index width; number of slots = 2^SLOT_W (ties to RAM addr)
- BYTE_W, 10, byte index width; max packet = 2^BYTE_W bytes (ties to RAM byte)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  ingress byte valid
- in_data  in  8  ingress byte
- in_last  in  1  final byte of packet
- in_ready  out  1  ingress byte accepted when in_valid && in_ready
- out_valid  out  1  egress byte valid
- out_data  out  8  egress byte
- out_last  out  1  final byte of packet
- out_ready  in  1  egress consumer ready
- ram_we  out  1  RAM write enable
- ram_addr  out  SLOT_W  RAM slot address
- ram_byte  out  BYTE_W  RAM byte select
- ram_data  out  8  RAM write data
- ram_q  in  8  RAM read data; slot address registered in RAM, byte select combinational
- pkt_count  out  SLOT_W+1  committed, not fully read packets
- drop  out  1  one-cycle pulse when an oversize packet is discarded

## Operation
- **State:**
  - wr_slot, wr_idx, rd_slot, rd_idx, count.
  - len[2^SLOT_W] table, BYTE_W+1 bits wide, holding lengths 1..2^BYTE_W.
  - prio bit.
- **Ingress write states:** W_RUN, W_DROP.
- **Egress FSM states:** E_IDLE, E_ISSUE, E_CAP, E_HOLD.
- **Port ownership, one owner per cycle, evaluated in this order:**
  1. E_CAP owns the port. ram_addr=rd_slot, ram_byte=rd_idx, ram_we=0. Writes are blocked.
  2. Else, if E_ISSUE and (prio==1 or !in_valid), the read issue owns the port. It drives the same ram_addr/ram_byte values with ram_we=0.
  3. Else the port belongs to ingress.
- **in_ready** = (W_DROP) or (W_RUN && count<2^SLOT_W && !E_CAP && !(E_ISSUE && prio==1)). in_ready has no combinational dependence on in_valid.
- **Ingress write (W_RUN):**
  - On in_valid && in_ready: ram_we=1, ram_addr=wr_slot, ram_byte=wr_idx, ram_data=in_data.
  - If in_last: len[wr_slot]=wr_idx+1, wr_slot++ (wraps), wr_idx=0, count++.
  - Else, if wr_idx==2^BYTE_W-1: go to W_DROP, wr_idx=0.
  - Else wr_idx++.
- **Drop (W_DROP):**
  - Accept and discard bytes with ram_we=0. The port stays free for reads.
  - On an accepted in_last: drop=1 for that cycle, return to W_RUN. The slot is not committed and wr_slot is unchanged.
- **prio:** toggles only on cycles where E_ISSUE and in_valid both contend. It is set to 0 after a read issue wins and to 1 after a write wins.
- **Egress FSM:**
  - E_IDLE → E_ISSUE when count>0.
  - E_ISSUE → E_CAP when the read issue owns the port.
  - E_CAP: out_data<=ram_q, out_last<=(rd_idx==len[rd_slot]-1); → E_HOLD.
  - E_HOLD: out_valid=1. On out_ready:
    - if out_last: rd_slot++ (wraps), rd_idx=0, count--, → E_IDLE.
    - else rd_idx++, → E_ISSUE.
- **count:** simultaneous commit and retire leave count unchanged. count never exceeds 2^SLOT_W and never underflows.
- **pkt_count** = count.
- **Reset (rst), any cycle, including mid-packet:**
  - All pointers, count, prio cleared; W_RUN and E_IDLE.
  - Outputs: in_ready=0 during reset; out_valid=0, out_last=0, out_data=0, ram_we=0, ram_addr=0, ram_byte=0, ram_data=0, drop=0, pkt_count=0.
  - A partial packet is abandoned. The len table need not be cleared.

## Timing
- Write: 1 port cycle per byte; RAM updates on the accept edge. With no egress contention, ingress sustains 1 byte/cycle.
- Read: 2 consecutive port cycles (issue, capture). out_valid rises the cycle after E_CAP. Minimum 3 cycles per egress byte.
- Commit-to-egress: a packet committed on edge N can enter E_ISSUE at N+1 at the earliest.
- Full: in_ready=0 in W_RUN while count==2^SLOT_W. It recovers the cycle after a retire.
- out_data and out_last are stable while out_valid && !out_ready.

## Test plan
- SLOT_W=2, BYTE_W=4. Ingress bytes A1,A2,A3 (last on A3), out_ready=1 → RAM slot 0 bytes 0..2 written; egress A1,A2,A3 with out_last only on A3; pkt_count goes 0→1→0.
- Ingress continuous 8-byte packets and egress out_ready=1 concurrently → reads and writes alternate on contention, no port cycle has two owners, and egress data matches ingress order.
- Five 2-byte packets with out_ready=0 → in_ready=0 after the fourth commit and pkt_count=4. Raising out_ready drains the packets in order; the fifth packet enters slot 0 after wrap.
- 20-byte packet with BYTE_W=4 → bytes 0..15 written, drop=1 pulse on byte 20 (last), pkt_count unchanged; a following 1-byte packet reuses the same slot.
- rst asserted mid-ingress (byte 2 of 5) and mid-egress (E_HOLD) → next cycle all outputs take reset values; a new packet afterwards lands in slot 0 and reads back correctly.
- out_ready held 0 for 10 cycles in E_HOLD → out_data/out_last held constant and no RAM read is issued.
